// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: display word layout,
// MMIO address and the active-low hex decode table.
package seg7_scan_driver_pkg;

  localparam logic [31:0] DISP_ADDR = 32'h4000_0010;

  localparam int DIG_LSB    = 0;
  localparam int DP_LSB     = 16;
  localparam int EN_LSB     = 20;
  localparam int LZS_BIT    = 24;
  localparam int RAW_BIT    = 25;
  localparam int RAW_SEG_LSB = 0;
  localparam int RAW_AN_LSB  = 8;

  // gfedcba, active-low, indexed by hex value
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex digit to active-low gfedcba segment decoder.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG7_LUT[digit_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a double-buffered display
// word committed on frame boundaries, plus a raw software-scanned passthrough.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  output logic [3:0]  an_n,
  output logic [7:0]  seg_n,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic        pending
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [31:0]      active_q, active_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic       wrap, boundary;
  logic [3:0] cur_digit, en, dp;
  logic [6:0] cur_seg;
  logic       upper_zero, visible;

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = wrap && (dig_q == 2'd3);

  assign cur_digit  = active_q[{dig_q, 2'b00} +: 4];
  assign en         = active_q[EN_LSB +: 4];
  assign dp         = active_q[DP_LSB +: 4];
  assign upper_zero = ((active_q[DIG_LSB +: 16] >> {dig_q, 2'b00}) == 16'd0);
  assign visible    = en[dig_q] && !(active_q[LZS_BIT] && (dig_q != 2'd0) && upper_zero);

  hex_to_seg7 u_dec (
    .digit_i (cur_digit),
    .seg_n_o (cur_seg)
  );

  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    dig_d    = wrap ? dig_q + 2'd1 : dig_q;
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    // Raw words, the first word after raw mode and boundary-cycle loads skip the shadow
    if (load) begin
      if (load_data[RAW_BIT] || active_q[RAW_BIT] || boundary) begin
        active_d = load_data;
        pend_d   = 1'b0;
      end else begin
        shadow_d = load_data;
        pend_d   = 1'b1;
      end
    end else if (boundary && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    // A raw load reaches the pins on the very next cycle
    if (load && load_data[RAW_BIT]) begin
      an_d  = load_data[RAW_AN_LSB +: 4];
      seg_d = load_data[RAW_SEG_LSB +: 8];
    end else if (active_q[RAW_BIT]) begin
      an_d  = active_q[RAW_AN_LSB +: 4];
      seg_d = active_q[RAW_SEG_LSB +: 8];
    end else if ((cnt_q >= CNT_BLANK) && visible) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {~dp[dig_q], cur_seg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      active_q <= 32'd0;
      shadow_q <= 32'd0;
      pend_q   <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign digit_idx  = dig_q;
  assign frame_done = boundary;
  assign pending    = pend_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Hardware-scanned 4-digit seven-segment display driver. It sits downstream of the data-memory MMIO write path and is fed by the same store that targets the display register at 0x40000010. Software writes one 32-bit display word; the block double-buffers it, commits it on frame boundaries so the display never tears, multiplexes the anodes and drives active-low segments. A raw mode passes software-scanned {an_n, seg_n} straight through.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range is 2 and above.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be less than CLK_DIV.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high
load  input  1  one-cycle write strobe (MemWrite && Address==0x40000010)
load_data  input  32  display word (fields below)
an_n  output  4  anode enables, active-low, registered
seg_n  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered
digit_idx  output  2  digit currently being driven
frame_done  output  1  one-cycle pulse when slot 3 ends
pending  output  1  shadow word waiting for commit

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- load_data fields:
  - [15:0] four hex digits, digit0 = [3:0].
  - [19:16] decimal points.
  - [23:20] digit enables.
  - [24] leading-zero suppress (lzs).
  - [25] raw mode.
  - In raw mode, [11:8] is an_n and [7:0] is seg_n.
- Reset values:
  - an_n=4'hF, seg_n=8'hFF, digit_idx=0, frame_done=0, pending=0.
  - Slot counter=0; active and shadow words=0, so the display is dark.
- Slot counter:
  - Counts 0..CLK_DIV-1, then wraps.
  - On wrap, digit_idx increments mod 4.
  - When digit_idx goes 3 to 0, frame_done pulses for that single cycle (the frame boundary).
- Load with raw=0:
  - Word goes to the shadow register and pending is set to 1.
  - Multiple loads within one frame: the last one wins.
  - At the frame boundary, if pending is set, shadow is copied to active and pending is cleared.
- Load on the frame-boundary cycle: load_data itself is written to active, bypassing the shadow, and pending ends at 0.
- Load with raw=1:
  - Written to active immediately; pending is cleared.
  - an_n and seg_n equal the raw bits one cycle after load.
  - The counter keeps running; blanking and decode are ignored.
- Leaving raw mode: the next non-raw load is written straight to active, with no wait for a frame.
- Normal output, registered (1-cycle latency from counter/active state):
  - When counter < BLANK_CYCLES, an_n=4'hF and seg_n=8'hFF.
  - Otherwise, an_n drives bit digit_idx low only if the digit is visible.
  - seg_n = {~dp[idx], hex_decode(digit[idx])}.
  - A non-visible digit gives an_n=4'hF and seg_n=8'hFF.
- Visible = enable[idx] && !(lzs && idx!=0 && all digits idx..3 are zero).
- Digit 0 is never zero-suppressed.
- Decode values (gfedcba, active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
- Reset mid-frame: outputs go dark immediately (async); scanning restarts from digit 0 and the counter at 0.

Decomposition:
- Shared package:
  - Decode constant table.
  - load_data field bit positions (DIG_LSB, DP_LSB, EN_LSB, LZS_BIT, RAW_BIT).
  - Display MMIO address 32'h40000010.
- Sub-module hex_to_seg7: combinational, 4-bit digit in, 7-bit active-low gfedcba out; instantiated once on the muxed digit.

Test Plan:
- Bench settings: CLK_DIV=8, BLANK_CYCLES=1.
- Reset then no load: an_n=F and seg_n=FF for 100 cycles; frame_done pulses every 32 cycles.
- Load 0x00F01234 mid-frame: pending=1 until the next frame_done, then commits.
  - Slot 0 shows an_n=E, seg_n=0x99 ("4", dp off).
  - Slot 3 shows an_n=7, seg_n=0xF9 ("1").
  - Cycle 0 of each slot is dark.
- Two loads in one frame (0x00F01111, then 0x00F02222): only 0x2222 is displayed after the boundary; 0x1111 never appears.
- Load coincident with frame_done: the word is active from the first slot of the new frame; pending=0 on the next cycle.
- Load 0x01F30007 (lzs on, dp0 and dp1 set): only digit 0 is lit, seg_n=0x78 ("7", dp on), an_n=E; slots 1-3 are dark.
- Load 0x02000B40 (raw): an_n=B, seg_n=0x40 on the next cycle and steady across slots; asserting reset mid-slot forces an_n=F and seg_n=FF at once.
